// File: rtl/shift_chain_pkg.sv
// Shared types and defaults for the serial shift-chain sequencer.
// Holds the FSM state encoding and the counter-width helper.
package shift_chain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // The counter must reach WIDTH+DEPTH-1, which always fits in this width.
    function automatic int cnt_w(input int width, input int depth);
        return $clog2(width + depth);
    endfunction

endpackage

// File: rtl/shift_chain_ctrl.sv
// Drives a parallel command word MSB-first into a DEPTH-stage serial chain
// and returns the word captured from the chain output DEPTH cycles later.
module shift_chain_ctrl
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_cmd_valid,
    output logic             io_cmd_ready,
    input  logic [WIDTH-1:0] io_cmd_bits,
    input  logic             io_abort,
    output logic             io_sr_in,
    input  logic             io_sr_out,
    output logic             io_rsp_valid,
    input  logic             io_rsp_ready,
    output logic [WIDTH-1:0] io_rsp_bits,
    output logic             io_busy
);

    localparam int CNT_W = cnt_w(WIDTH, DEPTH);
    localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(WIDTH + DEPTH - 1);
    localparam logic [CNT_W-1:0] WIDTH_CYC = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_CYC = CNT_W'(DEPTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [CNT_W-1:0] r_cyc;

    logic w_tx_window;
    logic w_rx_window;

    assign w_tx_window = (r_cyc < WIDTH_CYC);
    assign w_rx_window = (r_cyc >= DEPTH_CYC);

    // All outputs come from registers only; the chain input never sees a
    // combinational path from any controller input.
    assign io_cmd_ready = (r_state == IDLE);
    assign io_busy      = (r_state != IDLE);
    assign io_rsp_valid = (r_state == RESP);
    assign io_rsp_bits  = r_rx;
    assign io_sr_in     = (r_state == SHIFT) && w_tx_window && r_tx[WIDTH-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_cyc   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_cmd_valid) begin
                        r_tx    <= io_cmd_bits;
                        r_rx    <= '0;
                        r_cyc   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Abort wins over the counter advance and drops the partial word.
                    if (io_abort) begin
                        r_state <= IDLE;
                        r_tx    <= '0;
                        r_rx    <= '0;
                        r_cyc   <= '0;
                    end else begin
                        if (w_tx_window) begin
                            r_tx <= {r_tx[WIDTH-2:0], 1'b0};
                        end
                        if (w_rx_window) begin
                            r_rx <= {r_rx[WIDTH-2:0], io_sr_out};
                        end
                        if (r_cyc == LAST_CYC) begin
                            r_state <= RESP;
                        end else begin
                            r_cyc <= r_cyc + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (io_rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Directed bench for shift_chain_ctrl with a behavioural 4-stage chain
// that can optionally invert the data it carries.
module tb_shift_chain_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = WIDTH + DEPTH;

    logic             clock;
    logic             reset;
    logic             io_cmd_valid;
    logic             io_cmd_ready;
    logic [WIDTH-1:0] io_cmd_bits;
    logic             io_abort;
    logic             io_sr_in;
    logic             io_sr_out;
    logic             io_rsp_valid;
    logic             io_rsp_ready;
    logic [WIDTH-1:0] io_rsp_bits;
    logic             io_busy;

    logic [DEPTH-1:0] chain;
    logic             inv_sel;

    int n_vec;
    int n_err;

    shift_chain_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_cmd_valid (io_cmd_valid),
        .io_cmd_ready (io_cmd_ready),
        .io_cmd_bits  (io_cmd_bits),
        .io_abort     (io_abort),
        .io_sr_in     (io_sr_in),
        .io_sr_out    (io_sr_out),
        .io_rsp_valid (io_rsp_valid),
        .io_rsp_ready (io_rsp_ready),
        .io_rsp_bits  (io_rsp_bits),
        .io_busy      (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural chain: a bit entering at one edge leaves DEPTH cycles later.
    initial chain = '0;
    always @(posedge clock) chain <= {chain[DEPTH-2:0], io_sr_in};
    assign io_sr_out = chain[DEPTH-1] ^ inv_sel;

    typedef struct {
        logic [WIDTH-1:0] cmd;
        logic             inv;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Full transfer with io_rsp_ready high; checks the serial stream, the
    // busy window and the exact response latency.
    task automatic do_transfer(input logic [WIDTH-1:0] cmd, input logic inv,
                               input logic [WIDTH-1:0] exp);
        logic exp_bit;
        inv_sel      = inv;
        check("cmd_ready_before", io_cmd_ready, 1);
        io_cmd_valid = 1'b1;
        io_cmd_bits  = cmd;
        io_rsp_ready = 1'b1;
        tick();
        io_cmd_valid = 1'b0;
        for (int c = 0; c < LAT; c++) begin
            exp_bit = (c < WIDTH) ? cmd[WIDTH-1-c] : 1'b0;
            check($sformatf("sr_in_c%0d", c), io_sr_in, exp_bit);
            check($sformatf("busy_c%0d", c), io_busy, 1);
            check($sformatf("rsp_valid_early_c%0d", c), io_rsp_valid, 0);
            tick();
        end
        check("rsp_valid", io_rsp_valid, 1);
        check("rsp_bits", io_rsp_bits, exp);
        check("cmd_ready_in_resp", io_cmd_ready, 0);
        tick();
        check("busy_after", io_busy, 0);
        check("cmd_ready_after", io_cmd_ready, 1);
        check("rsp_valid_after", io_rsp_valid, 0);
        inv_sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{cmd: 8'hA5, inv: 1'b0, exp: 8'hA5};
        vecs[1] = '{cmd: 8'h3C, inv: 1'b1, exp: 8'hC3};
        vecs[2] = '{cmd: 8'h00, inv: 1'b0, exp: 8'h00};
        vecs[3] = '{cmd: 8'hFF, inv: 1'b0, exp: 8'hFF};
        vecs[4] = '{cmd: 8'h01, inv: 1'b1, exp: 8'hFE};
        vecs[5] = '{cmd: 8'h80, inv: 1'b0, exp: 8'h80};

        reset        = 1'b0;
        inv_sel      = 1'b0;
        io_cmd_valid = 1'b0;
        io_cmd_bits  = '0;
        io_abort     = 1'b0;
        io_rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_cmd_ready", io_cmd_ready, 1);
        check("rst_rsp_valid", io_rsp_valid, 0);
        check("rst_rsp_bits", io_rsp_bits, 0);
        check("rst_sr_in", io_sr_in, 0);
        check("rst_busy", io_busy, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_transfer(vecs[i].cmd, vecs[i].inv, vecs[i].exp);
        end

        // Backpressure: response must hold while the consumer stalls.
        io_cmd_valid = 1'b1;
        io_cmd_bits  = 8'h81;
        io_rsp_ready = 1'b0;
        tick();
        io_cmd_valid = 1'b0;
        repeat (LAT) tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", io_rsp_valid, 1);
            check("bp_rsp_bits", io_rsp_bits, 8'h81);
            check("bp_cmd_ready", io_cmd_ready, 0);
            tick();
        end
        check("bp_still_valid", io_rsp_valid, 1);
        io_rsp_ready = 1'b1;
        tick();
        check("bp_idle_busy", io_busy, 0);
        check("bp_idle_cmd_ready", io_cmd_ready, 1);

        // Back-to-back with io_cmd_valid held high throughout.
        io_cmd_valid = 1'b1;
        io_cmd_bits  = 8'h0F;
        io_rsp_ready = 1'b1;
        tick();
        io_cmd_bits  = 8'hF0;
        repeat (LAT) tick();
        check("b2b_rsp1_valid", io_rsp_valid, 1);
        check("b2b_rsp1_bits", io_rsp_bits, 8'h0F);
        check("b2b_rsp1_cmd_ready", io_cmd_ready, 0);
        tick();
        check("b2b_gap_cmd_ready", io_cmd_ready, 1);
        check("b2b_gap_busy", io_busy, 0);
        tick();
        io_cmd_valid = 1'b0;
        check("b2b_accept2_busy", io_busy, 1);
        repeat (LAT) tick();
        check("b2b_rsp2_valid", io_rsp_valid, 1);
        check("b2b_rsp2_bits", io_rsp_bits, 8'hF0);
        tick();
        check("b2b_done_busy", io_busy, 0);

        // Abort at cyc=3.
        io_cmd_valid = 1'b1;
        io_cmd_bits  = 8'hFF;
        tick();
        io_cmd_valid = 1'b0;
        repeat (3) tick();
        check("abort_pre_sr_in", io_sr_in, 1);
        io_abort = 1'b1;
        tick();
        io_abort = 1'b0;
        check("abort_cmd_ready", io_cmd_ready, 1);
        check("abort_sr_in", io_sr_in, 0);
        check("abort_busy", io_busy, 0);
        for (int k = 0; k < 20; k++) begin
            check("abort_no_rsp", io_rsp_valid, 0);
            tick();
        end

        // Abort together with a command in IDLE: the command wins.
        io_cmd_valid = 1'b1;
        io_cmd_bits  = 8'h3C;
        io_abort     = 1'b1;
        tick();
        io_cmd_valid = 1'b0;
        io_abort     = 1'b0;
        check("idle_abort_accepted", io_busy, 1);
        repeat (LAT) tick();
        check("idle_abort_rsp_valid", io_rsp_valid, 1);
        check("idle_abort_rsp_bits", io_rsp_bits, 8'h3C);
        tick();

        // Asynchronous reset at cyc=6, between clock edges.
        io_cmd_valid = 1'b1;
        io_cmd_bits  = 8'hC3;
        tick();
        io_cmd_valid = 1'b0;
        repeat (6) tick();
        check("rmid_pre_busy", io_busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rmid_sr_in", io_sr_in, 0);
        check("rmid_busy", io_busy, 0);
        check("rmid_rsp_valid", io_rsp_valid, 0);
        check("rmid_cmd_ready", io_cmd_ready, 1);
        tick();
        #3;
        reset = 1'b1;
        tick();
        for (int k = 0; k < 15; k++) begin
            check("rmid_no_rsp", io_rsp_valid, 0);
            tick();
        end
        do_transfer(8'h5A, 1'b0, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
